// File: rtl/axi4_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_cmd_master
//
// Single-outstanding AXI4-Lite master. Turns a valid/ready command stream
// into one AXI4-Lite read or write transaction per command, and returns one
// response per command on a valid/ready response stream. Every output is
// driven straight from a flop.
//
// Ports
//   clk, reset           clock (posedge) and synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr             byte address
//   cmd_wdata/cmd_wstrb  write data and byte strobes (ignored for reads)
//   rsp_valid/rsp_ready  response handshake
//   rsp_write            echo of the command direction
//   rsp_rdata            read data (0 for writes)
//   rsp_resp             BRESP/RRESP from the slave, unchanged
//   rsp_cycles           cycles from command accept to B/R handshake, saturating
//   aw*/w*/b*            AXI write address, write data, write response channels
//   ar*/r*               AXI read address and read data channels
// ---------------------------------------------------------------------------
module axi4_lite_cmd_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [CNT_WIDTH-1:0]    rsp_cycles,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
      $error("axi4_lite_cmd_master: DATA_WIDTH must be a power of two and >= 8");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD      = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == {CNT_WIDTH{1'b1}}) begin
         return v;
      end
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t                  state_q,     state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q,   awvalid_d;
   logic                    wvalid_q,    wvalid_d;
   logic                    bready_q,    bready_d;
   logic                    arvalid_q,   arvalid_d;
   logic                    rready_q,    rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    aw_done_q,   aw_done_d;
   logic                    w_done_q,    w_done_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
   logic                    rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q,  rsp_resp_d;
   logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               rsp_write_d = cmd_write;
               cnt_d       = '0;
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD;
               end
            end
         end

         WR: begin
            cnt_d = sat_inc(cnt_q);
            // AW and W retire independently; either may finish first.
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         WR_RESP: begin
            cnt_d = sat_inc(cnt_q);
            if (bvalid && bready_q) begin
               rsp_resp_d  = bresp;
               rsp_rdata_d = '0;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end

         RD: begin
            cnt_d = sat_inc(cnt_q);
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         RD_DATA: begin
            cnt_d = sat_inc(cnt_q);
            if (rvalid && rready_q) begin
               rsp_rdata_d = rdata;
               rsp_resp_d  = rresp;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end

         RSP: begin
            // Counter is frozen here; cmd_ready only rises after the handshake,
            // so the next command lands at the earliest one cycle later.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign awvalid    = awvalid_q;
   assign awaddr     = awaddr_q;
   assign wvalid     = wvalid_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign bready     = bready_q;
   assign arvalid    = arvalid_q;
   assign araddr     = araddr_q;
   assign rready     = rready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_write  = rsp_write_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_resp   = rsp_resp_q;
   assign rsp_cycles = cnt_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_cmd_master
//
// Bench for axi4_lite_cmd_master. A behavioural AXI4-Lite slave with
// per-channel ready/valid delays answers the master; a scoreboard queue holds
// the expected response of every command, and the slave side measures the
// accept-to-B/R span that rsp_cycles must report.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4_lite_cmd_master;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int CW  = 8;
   localparam int SW  = DW / 8;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [CW-1:0] rsp_cycles;
   logic          awvalid, awready;
   logic [AW-1:0] awaddr;
   logic          wvalid, wready;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          bvalid, bready;
   logic [1:0]    bresp;
   logic          arvalid, arready;
   logic [AW-1:0] araddr;
   logic          rvalid, rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;

   axi4_lite_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          wr;
      logic [DW-1:0] rd;
      logic [1:0]    resp;
   } exp_t;

   exp_t exp_q[$];
   int   exp_cyc_q[$];

   // slave configuration (written by tests)
   int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0]    cfg_bresp, cfg_rresp;
   logic [DW-1:0] cfg_rdata;

   // slave state and observations
   int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit            aw_pend, w_pend, b_pend, ar_pend, r_pend;
   bit            aw_got, w_got, ar_got;
   int            aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, acc_n;
   logic [AW-1:0] aw_addr_seen, ar_addr_seen;
   logic [DW-1:0] w_data_seen;
   logic [SW-1:0] w_strb_seen;
   int            cyc, acc_cyc;

   // previous-cycle view for valid/payload stability checks
   bit            p_aw, p_w, p_ar;
   logic [AW-1:0] p_awaddr, p_araddr;
   logic [DW-1:0] p_wdata;
   logic [SW-1:0] p_wstrb;

   task automatic slave_clear();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
   endtask

   // Slave + monitor: runs just after each negedge; a valid&ready seen here
   // is the handshake that the following posedge completes.
   initial begin
      bresp = 2'b00; rdata = '0; rresp = 2'b00;
      cyc = 0; acc_cyc = 0;
      slave_clear();
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (reset) begin
            slave_clear();
         end else begin
            if (p_aw) begin
               checks++;
               if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin
                  failures++;
                  $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1/%h", awvalid, awaddr, p_awaddr);
               end
            end
            if (p_w) begin
               checks++;
               if (wvalid !== 1'b1 || wdata !== p_wdata || wstrb !== p_wstrb) begin
                  failures++;
                  $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%h, required 1/%h/%h", wvalid, wdata, wstrb, p_wdata, p_wstrb);
               end
            end
            if (p_ar) begin
               checks++;
               if (arvalid !== 1'b1 || araddr !== p_araddr) begin
                  failures++;
                  $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1/%h", arvalid, araddr, p_araddr);
               end
            end

            // B channel (before AW/W so B never precedes their handshakes)
            if (b_pend) begin bvalid = 1'b0; b_pend = 0; aw_got = 0; w_got = 0; end
            if (aw_got && w_got && !bvalid) begin
               if (b_cnt >= b_dly) begin bvalid = 1'b1; bresp = cfg_bresp; end
               else b_cnt++;
            end
            if (bvalid && bready) begin
               b_pend = 1; b_hs_n++; b_cnt = 0;
               exp_cyc_q.push_back((cyc - acc_cyc) > SAT ? SAT : (cyc - acc_cyc));
            end

            // AW channel
            if (aw_pend) begin awready = 1'b0; aw_pend = 0; end
            if (awvalid && !awready) begin
               if (aw_cnt >= aw_dly) awready = 1'b1; else aw_cnt++;
            end
            if (awvalid && awready) begin
               aw_pend = 1; aw_hs_n++; aw_got = 1; aw_cnt = 0; aw_addr_seen = awaddr;
            end

            // W channel
            if (w_pend) begin wready = 1'b0; w_pend = 0; end
            if (wvalid && !wready) begin
               if (w_cnt >= w_dly) wready = 1'b1; else w_cnt++;
            end
            if (wvalid && wready) begin
               w_pend = 1; w_hs_n++; w_got = 1; w_cnt = 0; w_data_seen = wdata; w_strb_seen = wstrb;
            end

            // R channel (before AR for the same ordering reason)
            if (r_pend) begin rvalid = 1'b0; r_pend = 0; ar_got = 0; end
            if (ar_got && !rvalid) begin
               if (r_cnt >= r_dly) begin rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp; end
               else r_cnt++;
            end
            if (rvalid && rready) begin
               r_pend = 1; r_hs_n++; r_cnt = 0;
               exp_cyc_q.push_back((cyc - acc_cyc) > SAT ? SAT : (cyc - acc_cyc));
            end

            // AR channel
            if (ar_pend) begin arready = 1'b0; ar_pend = 0; end
            if (arvalid && !arready) begin
               if (ar_cnt >= ar_dly) arready = 1'b1; else ar_cnt++;
            end
            if (arvalid && arready) begin
               ar_pend = 1; ar_hs_n++; ar_got = 1; ar_cnt = 0; ar_addr_seen = araddr;
            end

            if (bready) begin
               checks++;
               if (!(aw_got && w_got)) begin
                  failures++;
                  $display("FAIL bready_early: bready=1 with aw_done=%0d w_done=%0d, required both 1", aw_got, w_got);
               end
            end
            if (awvalid || wvalid) begin
               checks++;
               if (arvalid !== 1'b0) begin
                  failures++;
                  $display("FAIL aw_ar_overlap: arvalid=%b while write active, required 0", arvalid);
               end
            end
            if (cmd_valid && cmd_ready) begin acc_cyc = cyc; acc_n++; end

            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
            p_ar = arvalid && !arready; p_araddr = araddr;
         end
      end
   end

   task automatic clear_counts();
      aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
   endtask

   task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [DW-1:0] exp_rd,
                           input logic [1:0] exp_resp, input bit push);
      int   n;
      exp_t e;
      if (push) begin
         e.wr = wr; e.rd = wr ? '0 : exp_rd; e.resp = exp_resp;
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      @(negedge clk);
      // scramble the command bus so any late sampling shows up
      cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d; cmd_wstrb = ~s; cmd_write = ~wr;
   endtask

   task automatic get_rsp(input int hold, output logic [CW-1:0] cyc_out);
      int            n;
      int            ec;
      exp_t          e;
      logic          w0;
      logic [DW-1:0] d0;
      logic [1:0]    r0;
      logic [CW-1:0] c0;
      cyc_out = '0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
         return;
      end
      w0 = rsp_write; d0 = rsp_rdata; r0 = rsp_resp; c0 = rsp_cycles;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_write !== w0 || rsp_rdata !== d0 ||
             rsp_resp !== r0 || rsp_cycles !== c0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rsp_hold: valid=%b wr=%b rdata=%h resp=%0d cyc=%0d cmd_ready=%b, required 1/%b/%h/%0d/%0d/0",
                     rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_cycles, cmd_ready, w0, d0, r0, c0);
         end
      end
      rsp_ready = 1'b1;
      cyc_out = rsp_cycles;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL rsp_unexpected: response with empty scoreboard");
      end else begin
         e = exp_q.pop_front();
         if (rsp_write !== e.wr || rsp_rdata !== e.rd || rsp_resp !== e.resp) begin
            failures++;
            $display("FAIL rsp_payload: wr=%b rdata=%h resp=%0d, required %b/%h/%0d",
                     rsp_write, rsp_rdata, rsp_resp, e.wr, e.rd, e.resp);
         end
      end
      checks++;
      if (exp_cyc_q.size() == 0) begin
         failures++;
         $display("FAIL rsp_cycles: no measured B/R handshake for this response");
      end else begin
         ec = exp_cyc_q.pop_front();
         if (int'(rsp_cycles) != ec) begin
            failures++;
            $display("FAIL rsp_cycles: got %0d, required %0d", rsp_cycles, ec);
         end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic check_count(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || {awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: cmd_ready=%b valids/readies=%b, required 1/000000",
                  cmd_ready, {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
      end
      checks++;
      if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || wstrb !== '0 ||
          rsp_rdata !== '0 || rsp_resp !== '0 || rsp_cycles !== '0 || rsp_write !== 1'b0) begin
         failures++;
         $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%0d cyc=%0d wr=%b, required all 0",
                  awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_cycles, rsp_write);
      end
      reset = 1'b0;
   endtask

   task automatic test_write();
      logic [CW-1:0] c;
      clear_counts();
      aw_dly = 1; w_dly = 1; b_dly = 1; cfg_bresp = 2'b00;
      send_cmd(1'b1, 4'h4, 32'h1234_5678, 4'hF, '0, 2'b00, 1);
      get_rsp(0, c);
      check_count("write_aw_hs", aw_hs_n, 1);
      check_count("write_w_hs", w_hs_n, 1);
      check_count("write_b_hs", b_hs_n, 1);
      check_count("write_awaddr", int'(aw_addr_seen), 4);
      checks++;
      if (w_data_seen !== 32'h1234_5678 || w_strb_seen !== 4'hF) begin
         failures++;
         $display("FAIL write_wdata: wdata=%h wstrb=%h, required 12345678/f", w_data_seen, w_strb_seen);
      end
   endtask

   task automatic test_read();
      logic [CW-1:0] c;
      clear_counts();
      ar_dly = 0; r_dly = 2; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
      send_cmd(1'b0, 4'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1);
      get_rsp(0, c);
      check_count("read_ar_hs", ar_hs_n, 1);
      check_count("read_r_hs", r_hs_n, 1);
      check_count("read_araddr", int'(ar_addr_seen), 8);
      check_count("read_no_aw", aw_hs_n, 0);
   endtask

   task automatic test_write_order();
      logic [CW-1:0] c;
      // W finishes 3 cycles before AW; slave reports SLVERR
      clear_counts();
      aw_dly = 3; w_dly = 0; b_dly = 0; cfg_bresp = 2'b10;
      send_cmd(1'b1, 4'hC, 32'hDEAD_BEEF, 4'h5, '0, 2'b10, 1);
      get_rsp(0, c);
      check_count("w_first_aw_hs", aw_hs_n, 1);
      check_count("w_first_w_hs", w_hs_n, 1);
      check_count("w_first_awaddr", int'(aw_addr_seen), 12);
      // AW finishes 3 cycles before W
      clear_counts();
      aw_dly = 0; w_dly = 3; b_dly = 2; cfg_bresp = 2'b00;
      send_cmd(1'b1, 4'h0, 32'h0F0F_0F0F, 4'h3, '0, 2'b00, 1);
      get_rsp(0, c);
      check_count("aw_first_aw_hs", aw_hs_n, 1);
      check_count("aw_first_w_hs", w_hs_n, 1);
      check_count("aw_first_wstrb", int'(w_strb_seen), 3);
      // both in the same cycle
      clear_counts();
      aw_dly = 2; w_dly = 2; b_dly = 0;
      send_cmd(1'b1, 4'h8, 32'h5555_AAAA, 4'hC, '0, 2'b00, 1);
      get_rsp(0, c);
      check_count("same_aw_hs", aw_hs_n, 1);
      check_count("same_w_hs", w_hs_n, 1);
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] c;
      exp_t          e;
      int            acc0;
      clear_counts();
      aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = 2'b00;
      ar_dly = 1; r_dly = 0; cfg_rdata = 32'hA5A5_0001; cfg_rresp = 2'b11;
      send_cmd(1'b1, 4'h4, 32'h0000_00FF, 4'h1, '0, 2'b00, 1);
      acc0 = acc_n;
      // second command waits on the bus through the whole held response
      e.wr = 1'b0; e.rd = 32'hA5A5_0001; e.resp = 2'b11;
      exp_q.push_back(e);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
      get_rsp(10, c);
      check_count("b2b_not_early", acc_n, acc0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_count("b2b_accepted", acc_n, acc0 + 1);
      get_rsp(0, c);
      check_count("b2b_ar_hs", ar_hs_n, 1);
   endtask

   task automatic test_saturate();
      logic [CW-1:0] c;
      clear_counts();
      ar_dly = 300; r_dly = 0; cfg_rdata = 32'h1357_9BDF; cfg_rresp = 2'b01;
      send_cmd(1'b0, 4'h0, 32'h0, 4'h0, 32'h1357_9BDF, 2'b01, 1);
      get_rsp(0, c);
      check_count("sat_cycles", int'(c), SAT);
   endtask

   task automatic test_reset_mid();
      logic [CW-1:0] c;
      clear_counts();
      aw_dly = 50; w_dly = 50; b_dly = 0;
      send_cmd(1'b1, 4'h4, 32'hFFFF_0000, 4'hF, '0, 2'b00, 0);
      checks++;
      if (awvalid !== 1'b1) begin
         failures++;
         $display("FAIL mid_awvalid: awvalid=%b before reset, required 1", awvalid);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: awvalid=%b wvalid=%b cmd_ready=%b rsp_valid=%b, required 0/0/1/0",
                  awvalid, wvalid, cmd_ready, rsp_valid);
      end
      exp_cyc_q.delete();
      clear_counts();
      ar_dly = 1; r_dly = 1; cfg_rdata = 32'h0BAD_BEEF; cfg_rresp = 2'b00;
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0, 32'h0BAD_BEEF, 2'b00, 1);
      get_rsp(0, c);
      check_count("post_reset_ar_hs", ar_hs_n, 1);
      check_count("post_reset_aw_hs", aw_hs_n, 0);
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
      acc_n = 0;
      clear_counts();
      test_reset();
      test_write();
      test_read();
      test_write_order();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
